// File: rtl/serializador_8b.sv
// -----------------------------------------------------------------------------
// serializador_8b
// Parallel-to-serial stage fed by the 32->8 width converter. Bytes arrive over a
// valid/ready handshake into a one-byte holding buffer and are shifted out one
// bit per clk. When no user byte is ready at a symbol boundary, IDLE_BYTE is
// sent instead, so the line never stalls mid-symbol.
//
// Ports:
//   clk        serial bit clock, all state changes on posedge
//   reset_L    asynchronous active-low reset
//   enable     1 = transmit, 0 = go quiet after the current symbol
//   data_in    byte from upstream
//   valid_in   data_in valid this cycle
//   ready_out  byte accepted this cycle when valid_in is also high (combinational)
//   data_out   serial bit (registered)
//   valid_out  data_out carries a bit of a symbol
//   is_data    current symbol is a user byte
//
// Build option:
//   SERIAL_MSB_FIRST_EN  defined   -> MSB first, shift register shifts left
//                        undefined -> LSB first, shift register shifts right
// -----------------------------------------------------------------------------
module serializador_8b #(
   parameter logic [7:0] IDLE_BYTE = 8'hBC,
   parameter int         BITS      = 8
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       enable,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       valid_out,
   output logic       is_data
);

   localparam logic [2:0] LAST_BIT = 3'(BITS - 1);

   typedef enum logic {
      ST_QUIET = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t     r_state;
   logic [7:0] r_shift;
   logic [2:0] r_cnt;
   logic [7:0] r_buf;
   logic       r_buf_full;
   logic       r_valid;
   logic       r_is_data;

   logic       w_boundary;
   logic       w_load;
   logic       w_load_buf;
   logic       w_xfer;
   logic [7:0] w_sym;
   logic       w_sym_is_data;

   // Advance the shift register by one bit in the configured direction.
   function automatic logic [7:0] f_shift(input logic [7:0] v);
`ifdef SERIAL_MSB_FIRST_EN
      return {v[6:0], 1'b0};
`else
      return {1'b0, v[7:1]};
`endif
   endfunction

   // A boundary is either the last bit of a symbol or any cycle spent quiet;
   // only when enable is high does it actually load a new symbol.
   assign w_boundary = (r_state == ST_QUIET) | ((r_state == ST_SHIFT) & (r_cnt == LAST_BIT));
   assign w_load     = w_boundary & enable;
   assign w_load_buf = w_load & r_buf_full;

   // The buffer can take a new byte on the same edge it drains into the shifter.
   assign ready_out  = ~r_buf_full | w_load_buf;
   assign w_xfer     = valid_in & ready_out;

`ifdef SERIAL_MSB_FIRST_EN
   assign data_out  = r_shift[7];
`else
   assign data_out  = r_shift[0];
`endif
   assign valid_out = r_valid;
   assign is_data   = r_is_data;

   // Pick the next symbol: buffered byte first, then a same-cycle bypass, else idle.
   always_comb begin
      w_sym         = IDLE_BYTE;
      w_sym_is_data = 1'b0;
      if (r_buf_full) begin
         w_sym         = r_buf;
         w_sym_is_data = 1'b1;
      end else if (w_xfer) begin
         w_sym         = data_in;
         w_sym_is_data = 1'b1;
      end else begin
         w_sym         = IDLE_BYTE;
         w_sym_is_data = 1'b0;
      end
   end

   // Line state machine: symbol loading, shifting, bit counting and output flags.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state   <= ST_QUIET;
         r_shift   <= 8'h00;
         r_cnt     <= 3'd0;
         r_valid   <= 1'b0;
         r_is_data <= 1'b0;
      end else begin
         case (r_state)
            ST_QUIET: begin
               r_cnt <= 3'd0;
               if (enable) begin
                  r_state   <= ST_SHIFT;
                  r_shift   <= w_sym;
                  r_valid   <= 1'b1;
                  r_is_data <= w_sym_is_data;
               end else begin
                  r_state   <= ST_QUIET;
                  r_shift   <= 8'h00;
                  r_valid   <= 1'b0;
                  r_is_data <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // Counter wraps 7 -> 0 naturally at the symbol boundary.
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == LAST_BIT) begin
                  if (enable) begin
                     r_state   <= ST_SHIFT;
                     r_shift   <= w_sym;
                     r_valid   <= 1'b1;
                     r_is_data <= w_sym_is_data;
                  end else begin
                     r_state   <= ST_QUIET;
                     r_shift   <= 8'h00;
                     r_cnt     <= 3'd0;
                     r_valid   <= 1'b0;
                     r_is_data <= 1'b0;
                  end
               end else begin
                  r_shift <= f_shift(r_shift);
               end
            end
            default: begin
               r_state   <= ST_QUIET;
               r_shift   <= 8'h00;
               r_cnt     <= 3'd0;
               r_valid   <= 1'b0;
               r_is_data <= 1'b0;
            end
         endcase
      end
   end

   // Holding buffer: drains at a loading boundary, may refill on the same edge.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_buf      <= 8'h00;
         r_buf_full <= 1'b0;
      end else if (w_load_buf) begin
         r_buf_full <= w_xfer;
         if (w_xfer) begin
            r_buf <= data_in;
         end
      end else if (w_xfer && !w_load) begin
         // Bypass transfers go straight to the shifter and never touch the buffer.
         r_buf      <= data_in;
         r_buf_full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_serializador_8b.sv
// -----------------------------------------------------------------------------
// tb_serializador_8b
// Self-checking bench for serializador_8b. A behavioural model keeps a queue of
// accepted-but-unsent bytes and a queue of the bits still to appear on the line;
// every cycle the DUT outputs are compared against it. Directed sequences pin
// the model with literal bit patterns; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_serializador_8b;

   localparam logic [7:0] IDLE = 8'hBC;
`ifdef SERIAL_MSB_FIRST_EN
   localparam logic [15:0] EXP_IDLE16 = 16'h3D3D;  // line order 1,0,1,1,1,1,0,0
`else
   localparam logic [15:0] EXP_IDLE16 = 16'hBCBC;  // line order 0,0,1,1,1,1,0,1
`endif

   logic       clk = 1'b0;
   logic       reset_L;
   logic       enable;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       data_out;
   logic       valid_out;
   logic       is_data;

   int n_vec = 0;
   int n_err = 0;

   // model state
   logic [7:0] mq[$];      // accepted bytes not yet started
   logic [1:0] msym[$];    // {is_data, bit} still to be shown, front = on the line now
   bit         mactive = 1'b0;

   // last sampled outputs
   logic obs_d, obs_v, obs_i, obs_r, obs_x;

   serializador_8b dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .enable    (enable),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .is_data   (is_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_bnd();
      return (!mactive) || (msym.size() == 1);
   endfunction

   function automatic bit model_ready(input logic en);
      return (mq.size() == 0) || (model_bnd() && en && (mq.size() != 0));
   endfunction

   task automatic push_sym(input logic [7:0] b, input bit dat);
      for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_MSB_FIRST_EN
         msym.push_back({dat, b[7-i]});
`else
         msym.push_back({dat, b[i]});
`endif
      end
   endtask

   task automatic model_clear();
      mq.delete();
      msym.delete();
      mactive = 1'b0;
   endtask

   task automatic model_update(input logic en, input logic v, input logic [7:0] d);
      bit bnd;
      bit xf;
      bnd = model_bnd();
      xf  = v && model_ready(en);
      if (xf) mq.push_back(d);
      if (bnd) begin
         msym.delete();
         if (en) begin
            mactive = 1'b1;
            if (mq.size() != 0) push_sym(mq.pop_front(), 1'b1);
            else                push_sym(IDLE, 1'b0);
         end else begin
            mactive = 1'b0;
         end
      end else begin
         void'(msym.pop_front());
      end
   endtask

   // One clock: drive inputs, compare at negedge, advance model at posedge.
   task automatic step(input logic en, input logic v, input logic [7:0] d);
      logic [1:0] e;
      logic exp_d, exp_v, exp_i, exp_r;
      enable   = en;
      valid_in = v;
      data_in  = d;
      @(negedge clk);
      if (mactive) begin
         e = msym[0];
         exp_d = e[0];
         exp_i = e[1];
         exp_v = 1'b1;
      end else begin
         exp_d = 1'b0;
         exp_i = 1'b0;
         exp_v = 1'b0;
      end
      exp_r = model_ready(en);
      chk("data_out",  32'(data_out),  32'(exp_d));
      chk("valid_out", 32'(valid_out), 32'(exp_v));
      chk("is_data",   32'(is_data),   32'(exp_i));
      chk("ready_out", 32'(ready_out), 32'(exp_r));
      obs_d = data_out;
      obs_v = valid_out;
      obs_i = is_data;
      obs_r = ready_out;
      obs_x = v & ready_out;
      @(posedge clk);
      model_update(en, v, d);
      #1;
   endtask

   // Asynchronous reset between clock edges; outputs must clear without a clock.
   task automatic do_reset();
      reset_L  = 1'b0;
      enable   = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;
      #1;
      model_clear();
      chk("rst_data_out",  32'(data_out),  32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_is_data",   32'(is_data),   32'd0);
      chk("rst_ready_out", 32'(ready_out), 32'd1);
      @(negedge clk);
      reset_L = 1'b1;
      @(posedge clk);
      model_update(1'b0, 1'b0, 8'h00);
      #1;
   endtask

   task automatic wait_boundary();
      for (int g = 0; g < 20 && !model_bnd(); g++) step(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      logic [15:0] cap16;
      logic [7:0]  cap8;
      logic [23:0] val24;
      int          cnt_v, cnt_i, k, start;
      bit          dropped;
      logic        log_d[60];
      logic        log_i[60];

      reset_L  = 1'b1;
      enable   = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;
      #3;
      do_reset();

      // Idle stream after reset with enable high.
      step(1'b1, 1'b0, 8'h00);
      cap16 = 16'h0000; cnt_v = 0; cnt_i = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'h00);
         cap16[i] = obs_d;
         cnt_v += int'(obs_v);
         cnt_i += int'(obs_i);
      end
      chk("idle_pattern", 32'(cap16), 32'(EXP_IDLE16));
      chk("idle_valid_cnt", 32'(cnt_v), 32'd16);
      chk("idle_isdata_cnt", 32'(cnt_i), 32'd0);

      // Single byte A5 accepted at an idle boundary.
      wait_boundary();
      step(1'b1, 1'b1, 8'hA5);
      chk("a5_accepted", 32'(obs_x), 32'd1);
      cap8 = 8'h00; cnt_i = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'h00);
         cap8[i] = obs_d;
         cnt_i += int'(obs_i);
      end
      chk("a5_bits", 32'(cap8), 32'h0000_00A5);
      chk("a5_isdata_cnt", 32'(cnt_i), 32'd8);
      step(1'b1, 1'b0, 8'h00);
      chk("idle_after_a5", 32'(obs_i), 32'd0);

      // Back-to-back 01,02,03 with valid held until all three transfer.
      k = 0; dropped = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, (k < 3), 8'(8'h01 + k));
         log_d[i] = obs_d;
         log_i[i] = obs_i;
         if (k < 3 && !obs_r) dropped = 1'b1;
         if (obs_x) k++;
      end
      chk("b2b_xfers", 32'(k), 32'd3);
      chk("b2b_ready_drop", 32'(dropped), 32'd1);
      start = 60;
      for (int i = 59; i >= 0; i--) if (log_i[i]) start = i;
      cnt_i = 0; val24 = 24'h0;
      for (int i = 0; i < 24; i++) begin
         if (start + i < 60) begin
            cnt_i += int'(log_i[start+i]);
`ifdef SERIAL_MSB_FIRST_EN
            val24[(i/8)*8 + (7 - i%8)] = log_d[start+i];
`else
            val24[i] = log_d[start+i];
`endif
         end
      end
      chk("b2b_contiguous", 32'(cnt_i), 32'd24);
      chk("b2b_bytes", 32'(val24), 32'h0003_0201);

      // enable dropped while bit 3 of a data symbol is on the line.
      wait_boundary();
      step(1'b1, 1'b1, 8'h3C);
      cnt_v = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h00);
         cnt_v += int'(obs_v);
      end
      step(1'b0, 1'b1, 8'h5A);
      cnt_v += int'(obs_v);
      chk("drop_5a_accepted", 32'(obs_x), 32'd1);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 8'h00);
         cnt_v += int'(obs_v);
      end
      chk("drop_sym_len", 32'(cnt_v), 32'd8);
      chk("drop_quiet", 32'(obs_v), 32'd0);
      step(1'b1, 1'b0, 8'h00);
      cap8 = 8'h00; cnt_i = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'h00);
         cap8[i] = obs_d;
         cnt_i += int'(obs_i);
      end
      chk("resume_5a_bits", 32'(cap8), 32'h0000_005A);
      chk("resume_5a_isdata", 32'(cnt_i), 32'd8);

      // Reset mid-symbol with a byte in the buffer; it must never appear.
      wait_boundary();
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b1, 8'h22);
      step(1'b1, 1'b0, 8'h00);
      chk("buf_full_not_ready", 32'(obs_r), 32'd0);
      do_reset();
      cnt_i = 0;
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, 8'h00);
         cnt_i += int'(obs_i);
      end
      chk("no_data_after_reset", 32'(cnt_i), 32'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999) do_reset();
         step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
